// File: rtl/wb_slave_decoder_if.sv
// Wishbone bus bundle for wb_slave_decoder: one master request/response plus
// flat NUM_SLAVES-wide slave vectors (slave 0 in the LSB slice).
interface wb_slave_decoder_if #(
    parameter int NUM_SLAVES = 11,
    parameter int AW         = 32,
    parameter int DW         = 32
);
    logic [AW-1:0]                wbm_adr_i;
    logic [DW-1:0]                wbm_dat_i;
    logic [DW/8-1:0]              wbm_sel_i;
    logic                         wbm_we_i;
    logic                         wbm_cyc_i;
    logic                         wbm_stb_i;
    logic [2:0]                   wbm_cti_i;
    logic [1:0]                   wbm_bte_i;
    logic [DW-1:0]                wbm_dat_o;
    logic                         wbm_ack_o;
    logic                         wbm_err_o;
    logic                         wbm_rty_o;

    logic [NUM_SLAVES*AW-1:0]     wbs_adr_o;
    logic [NUM_SLAVES*DW-1:0]     wbs_dat_o;
    logic [NUM_SLAVES*DW/8-1:0]   wbs_sel_o;
    logic [NUM_SLAVES-1:0]        wbs_we_o;
    logic [NUM_SLAVES-1:0]        wbs_cyc_o;
    logic [NUM_SLAVES-1:0]        wbs_stb_o;
    logic [NUM_SLAVES*3-1:0]      wbs_cti_o;
    logic [NUM_SLAVES*2-1:0]      wbs_bte_o;
    logic [NUM_SLAVES*DW-1:0]     wbs_dat_i;
    logic [NUM_SLAVES-1:0]        wbs_ack_i;
    logic [NUM_SLAVES-1:0]        wbs_err_i;
    logic [NUM_SLAVES-1:0]        wbs_rty_i;

    // Decoder view: it is the slave of the upstream master.
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_adr_o, wbs_dat_o,
               wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_adr_o, wbs_dat_o,
               wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
    );
endinterface

// File: rtl/wb_slave_decoder.sv
// Wishbone 1-to-N address decoder with decode-miss error capture.
// Define WB_DECODE_TIMEOUT_EN to add the slave response watchdog (TMOERR).
module wb_slave_decoder #(
    parameter int                          NUM_SLAVES = 11,
    parameter int                          AW         = 32,
    parameter int                          DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0]    MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0]    MATCH_MASK = '0,
    parameter int                          TIMEOUT    = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    wb_slave_decoder_if.slave    bus,
    output logic                 err_valid_o,
    output logic [1:0]           err_code_o,
    output logic [AW-1:0]        err_adr_o,
    input  logic                 err_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DECERR = 2'b10,
        ST_TMOERR = 2'b11
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [NUM_SLAVES-1:0] sel_r;
    logic [NUM_SLAVES-1:0] sel_nxt_s;
    logic [NUM_SLAVES-1:0] hit_onehot_s;
    logic                  hit_any_s;
    logic                  resp_ack_s;
    logic                  resp_err_s;
    logic                  resp_rty_s;
    logic                  resp_any_s;
    logic                  fwd_s;
    logic                  tmo_hit_s;
    logic [DW-1:0]         sel_dat_s;
    logic                  err_entry_s;
    logic [1:0]            err_code_nxt_s;
    logic                  err_valid_r;
    logic [1:0]            err_code_r;
    logic [AW-1:0]         err_adr_r;

    function automatic logic slave_hit(input logic [AW-1:0] adr, input int idx);
        logic [AW-1:0] base;
        logic [AW-1:0] mask;
        base = MATCH_ADDR[idx*AW +: AW];
        mask = MATCH_MASK[idx*AW +: AW];
        return (adr & mask) == (base & mask);
    endfunction

    // Request fields go to every slave untouched; only cyc/stb are steered.
    assign bus.wbs_adr_o = {NUM_SLAVES{bus.wbm_adr_i}};
    assign bus.wbs_dat_o = {NUM_SLAVES{bus.wbm_dat_i}};
    assign bus.wbs_sel_o = {NUM_SLAVES{bus.wbm_sel_i}};
    assign bus.wbs_we_o  = {NUM_SLAVES{bus.wbm_we_i}};
    assign bus.wbs_cti_o = {NUM_SLAVES{bus.wbm_cti_i}};
    assign bus.wbs_bte_o = {NUM_SLAVES{bus.wbm_bte_i}};

    // Address decode, lowest matching index wins
    always_comb begin
        hit_onehot_s = '0;
        hit_any_s    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit_onehot_s[i] = slave_hit(bus.wbm_adr_i, i) & ~hit_any_s;
            hit_any_s       = hit_any_s | hit_onehot_s[i];
        end
    end

    assign resp_ack_s = |(sel_r & bus.wbs_ack_i);
    assign resp_err_s = |(sel_r & bus.wbs_err_i);
    assign resp_rty_s = |(sel_r & bus.wbs_rty_i);
    assign resp_any_s = resp_ack_s | resp_err_s | resp_rty_s;
    assign fwd_s      = (state_r == ST_ACTIVE) & bus.wbm_cyc_i;

    // Read data mux over the registered one-hot select
    always_comb begin
        sel_dat_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_dat_s = sel_dat_s | ({DW{sel_r[i]}} & bus.wbs_dat_i[i*DW +: DW]);
        end
    end

`ifdef WB_DECODE_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;

    assign tmo_hit_s = (tmo_cnt_r == 16'(TIMEOUT - 1));

    // Watchdog: held at zero outside ACTIVE so every entry starts from zero
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r != ST_ACTIVE) begin
            tmo_cnt_r <= 16'd0;
        end else if (!resp_any_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    logic unused_tmo_s;

    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = ^16'(TIMEOUT);
`endif

    // FSM state and slave select registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
        end
    end

    // Next-state logic; every beat is re-decoded from IDLE
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                    sel_nxt_s   = hit_onehot_s;
                    state_nxt_s = hit_any_s ? ST_ACTIVE : ST_DECERR;
                end else begin
                    sel_nxt_s   = '0;
                end
            end
            ST_ACTIVE: begin
                if (!bus.wbm_cyc_i || resp_any_s) begin
                    state_nxt_s = ST_IDLE;
                    sel_nxt_s   = '0;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_TMOERR;
                    sel_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_DECERR: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = '0;
            end
`ifdef WB_DECODE_TIMEOUT_EN
            ST_TMOERR: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = '0;
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = '0;
            end
        endcase
    end

    // Bus outputs; slave responses pass through combinationally while ACTIVE
    always_comb begin
        if (state_r == ST_ACTIVE) begin
            bus.wbs_cyc_o = sel_r & {NUM_SLAVES{bus.wbm_cyc_i}};
            bus.wbs_stb_o = sel_r & {NUM_SLAVES{bus.wbm_stb_i}};
        end else begin
            bus.wbs_cyc_o = '0;
            bus.wbs_stb_o = '0;
        end
        bus.wbm_ack_o = fwd_s & resp_ack_s;
        bus.wbm_rty_o = fwd_s & resp_rty_s;
        bus.wbm_err_o = (fwd_s & resp_err_s) | (state_r == ST_DECERR) |
                        (state_r == ST_TMOERR);
        bus.wbm_dat_o = fwd_s ? sel_dat_s : '0;
    end

    assign err_entry_s    = ((state_nxt_s == ST_DECERR) || (state_nxt_s == ST_TMOERR)) &&
                            (state_nxt_s != state_r);
    assign err_code_nxt_s = (state_nxt_s == ST_TMOERR) ? 2'b10 : 2'b01;

    // Sticky error capture; a clear that meets a new error keeps the new one
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            err_valid_r <= 1'b0;
            err_code_r  <= 2'b00;
            err_adr_r   <= '0;
        end else if (err_entry_s && (!err_valid_r || err_clr_i)) begin
            err_valid_r <= 1'b1;
            err_code_r  <= err_code_nxt_s;
            err_adr_r   <= bus.wbm_adr_i;
        end else if (err_clr_i) begin
            err_valid_r <= 1'b0;
            err_code_r  <= 2'b00;
            err_adr_r   <= '0;
        end else begin
            err_valid_r <= err_valid_r;
            err_code_r  <= err_code_r;
            err_adr_r   <= err_adr_r;
        end
    end

    assign err_valid_o = err_valid_r;
    assign err_code_o  = err_code_r;
    assign err_adr_o   = err_adr_r;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Bench for wb_slave_decoder: table of transfers checked through a scoreboard
// queue, plus hand-written cyc-abort, watchdog and mid-transfer reset sequences.
module tb_wb_slave_decoder;

    localparam int NS = 3;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [1:0]  kind;   // 0 ack, 1 err, 2 rty
        logic [31:0] dat;
        logic [2:0]  cyc;    // slave cyc seen during the transfer
        logic [2:0]  rcyc;   // slave cyc in the response cycle
        int          n;      // sampling cycle of the response, 1 = drive cycle
        logic        errv;
        logic [1:0]  code;
        logic [31:0] eadr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        err_clr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_adr;
    int          errors;
    int          checks;
    vec_t        sb_q[$];
    vec_t        vecs[10];
    vec_t        v;
    int          lat[NS];
    logic        silent[NS];
    int          s_cnt[NS];
    logic [2:0]  s_ack_r;
    logic [2:0]  s_err_r;
    logic [2:0]  s_rty_r;

    wb_slave_decoder_if #(.NUM_SLAVES(NS), .AW(32), .DW(32)) bus ();

    wb_slave_decoder #(
        .NUM_SLAVES(NS),
        .AW(32),
        .DW(32),
        .MATCH_ADDR({32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .MATCH_MASK({32'hFFFF_F000, 32'hFFFF_FFC0, 32'hFFFF_F000}),
        .TIMEOUT(8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus),
        .err_valid_o(err_valid),
        .err_code_o (err_code),
        .err_adr_o  (err_adr),
        .err_clr_i  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave responders: slave0 acks (errs above 0x800), slave1 acks, slave2 retries
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack_r <= 3'b000;
            s_err_r <= 3'b000;
            s_rty_r <= 3'b000;
            for (int i = 0; i < NS; i++) s_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (bus.wbs_cyc_o[i] && bus.wbs_stb_o[i] && !silent[i] &&
                    !(s_ack_r[i] | s_err_r[i] | s_rty_r[i])) begin
                    if (s_cnt[i] == lat[i] - 1) begin
                        s_cnt[i]   <= 0;
                        s_ack_r[i] <= (i == 1) || (i == 0 && !bus.wbs_adr_o[11]);
                        s_err_r[i] <= (i == 0 && bus.wbs_adr_o[11]);
                        s_rty_r[i] <= (i == 2);
                    end else begin
                        s_cnt[i] <= s_cnt[i] + 1;
                    end
                end else begin
                    s_cnt[i]   <= 0;
                    s_ack_r[i] <= 1'b0;
                    s_err_r[i] <= 1'b0;
                    s_rty_r[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.wbs_ack_i = s_ack_r;
    assign bus.wbs_err_i = s_err_r;
    assign bus.wbs_rty_i = s_rty_r;
    assign bus.wbs_dat_i = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

    task automatic check(input string name, input string what,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: actual=%0h required=%0h", name, what, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, "idle_cyc", {125'd0, bus.wbs_cyc_o}, 128'd0);
        check(name, "idle_rsp", {125'd0, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 128'd0);
        check(name, "idle_dat", {96'd0, bus.wbm_dat_o}, 128'd0);
    endtask

    task automatic master_idle();
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
    endtask

    task automatic master_drive(input logic [31:0] adr, input logic we);
        bus.wbm_adr_i = adr;
        bus.wbm_we_i  = we;
        bus.wbm_dat_i = ~adr;
        bus.wbm_sel_i = 4'hF;
        bus.wbm_cti_i = 3'b000;
        bus.wbm_bte_i = 2'b00;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
    endtask

    task automatic clr_err(input string name);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check(name, "errv", {127'd0, err_valid}, 128'd0);
        check(name, "code", {126'd0, err_code}, 128'd0);
        check(name, "eadr", {96'd0, err_adr}, 128'd0);
    endtask

    task automatic run_vec(input vec_t tv, input logic clr, input string name);
        vec_t       e;
        int         n;
        logic       got;
        logic [2:0] seen;
        logic [1:0] kind;
        logic [31:0] dat;
        logic [2:0] rcyc;
        @(posedge clk); #1;
        master_drive(tv.adr, tv.we);
        err_clr = clr;
        sb_q.push_back(tv);
        n = 0; got = 1'b0; seen = 3'b000; kind = 2'd3; dat = 32'd0; rcyc = 3'b000;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check(name, "bcast_adr", {32'd0, bus.wbs_adr_o}, {32'd0, {3{tv.adr}}});
                check(name, "bcast_dat", {32'd0, bus.wbs_dat_o}, {32'd0, {3{~tv.adr}}});
                check(name, "bcast_we_sel", {113'd0, bus.wbs_we_o, bus.wbs_sel_o},
                      {113'd0, {3{tv.we}}, 12'hFFF});
            end
            if (n == 2) err_clr = 1'b0;
            seen |= bus.wbs_cyc_o;
            if (bus.wbm_ack_o || bus.wbm_err_o || bus.wbm_rty_o) begin
                got  = 1'b1;
                kind = bus.wbm_ack_o ? 2'd0 : (bus.wbm_err_o ? 2'd1 : 2'd2);
                dat  = bus.wbm_dat_o;
                rcyc = bus.wbs_cyc_o;
            end
        end
        err_clr = 1'b0;
        e = sb_q.pop_front();
        check(name, "resp_seen", {127'd0, got}, 128'd1);
        if (got) begin
            check(name, "kind", {126'd0, kind}, {126'd0, e.kind});
            check(name, "dat", {96'd0, dat}, {96'd0, e.dat});
            check(name, "latency", 128'(n), 128'(e.n));
            check(name, "resp_cyc", {125'd0, rcyc}, {125'd0, e.rcyc});
        end
        check(name, "seen_cyc", {125'd0, seen}, {125'd0, e.cyc});
        @(posedge clk); #1;
        master_idle();
        @(negedge clk);
        check_idle(name);
        check(name, "errv", {127'd0, err_valid}, {127'd0, e.errv});
        check(name, "code", {126'd0, err_code}, {126'd0, e.code});
        check(name, "eadr", {96'd0, err_adr}, {96'd0, e.eadr});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; err_clr = 1'b0;
        lat[0] = 1; lat[1] = 2; lat[2] = 3;
        for (int i = 0; i < NS; i++) silent[i] = 1'b0;
        bus.wbm_adr_i = 32'd0; bus.wbm_dat_i = 32'd0; bus.wbm_sel_i = 4'h0;
        bus.wbm_we_i = 1'b0; bus.wbm_cti_i = 3'b000; bus.wbm_bte_i = 2'b00;
        master_idle();

        //        adr            we    kind  dat            cyc     rcyc    n  errv  code   eadr
        vecs[0] = '{32'h0000_1004, 1'b0, 2'd0, 32'hCAFE_0001, 3'b010, 3'b010, 4, 1'b0, 2'b00, 32'h0};
        vecs[1] = '{32'h0000_0010, 1'b1, 2'd0, 32'hCAFE_0000, 3'b001, 3'b001, 3, 1'b0, 2'b00, 32'h0};
        vecs[2] = '{32'h0000_0804, 1'b0, 2'd1, 32'hCAFE_0000, 3'b001, 3'b001, 3, 1'b0, 2'b00, 32'h0};
        vecs[3] = '{32'h0000_2010, 1'b0, 2'd2, 32'hCAFE_0002, 3'b100, 3'b100, 5, 1'b0, 2'b00, 32'h0};
        vecs[4] = '{32'h0000_103C, 1'b1, 2'd0, 32'hCAFE_0001, 3'b010, 3'b010, 4, 1'b0, 2'b00, 32'h0};
        vecs[5] = '{32'h0000_07FC, 1'b0, 2'd0, 32'hCAFE_0000, 3'b001, 3'b001, 3, 1'b0, 2'b00, 32'h0};
        vecs[6] = '{32'h0000_3000, 1'b1, 2'd1, 32'h0000_0000, 3'b000, 3'b000, 2, 1'b1, 2'b01, 32'h3000};
        vecs[7] = '{32'h0000_4000, 1'b0, 2'd1, 32'h0000_0000, 3'b000, 3'b000, 2, 1'b1, 2'b01, 32'h3000};
        vecs[8] = '{32'h0000_1040, 1'b0, 2'd1, 32'h0000_0000, 3'b000, 3'b000, 2, 1'b1, 2'b01, 32'h3000};
        vecs[9] = '{32'h0000_2FFC, 1'b0, 2'd2, 32'hCAFE_0002, 3'b100, 3'b100, 5, 1'b1, 2'b01, 32'h3000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset", "err_regs", {93'd0, err_valid, err_code, err_adr}, 128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        clr_err("clr");

        // Clear pulse landing on the same edge as a new miss keeps the new miss
        v = '{32'h0000_6000, 1'b0, 2'd1, 32'h0, 3'b000, 3'b000, 2, 1'b1, 2'b01, 32'h6000};
        run_vec(v, 1'b0, "miss6000");
        v = '{32'h0000_5000, 1'b0, 2'd1, 32'h0, 3'b000, 3'b000, 2, 1'b1, 2'b01, 32'h5000};
        run_vec(v, 1'b1, "clr_and_miss");
        clr_err("clr2");

        // Master abandons an ACTIVE cycle: slave cyc drops in the same cycle
        silent[2] = 1'b1;
        @(posedge clk); #1 master_drive(32'h0000_2020, 1'b0);
        repeat (2) @(negedge clk);
        check("abort", "active_cyc", {125'd0, bus.wbs_cyc_o}, 128'd4);
        @(posedge clk); #1 master_idle();
        @(negedge clk);
        check("abort", "drop_cyc", {125'd0, bus.wbs_cyc_o}, 128'd0);
        check("abort", "no_rsp", {125'd0, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 128'd0);
        @(negedge clk);
        check_idle("abort_next");
        v = '{32'h0000_1004, 1'b0, 2'd0, 32'hCAFE_0001, 3'b010, 3'b010, 4, 1'b0, 2'b00, 32'h0};
        run_vec(v, 1'b0, "after_abort");

`ifdef WB_DECODE_TIMEOUT_EN
        v = '{32'h0000_2010, 1'b0, 2'd1, 32'h0, 3'b100, 3'b000, 10, 1'b1, 2'b10, 32'h2010};
        run_vec(v, 1'b0, "timeout");
`else
        @(posedge clk); #1 master_drive(32'h0000_2010, 1'b0);
        repeat (30) @(negedge clk);
        check("no_timeout", "cyc_held", {125'd0, bus.wbs_cyc_o}, 128'd4);
        check("no_timeout", "no_rsp", {125'd0, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 128'd0);
        check("no_timeout", "errv", {127'd0, err_valid}, 128'd0);
        @(posedge clk); #1 master_idle();
        @(negedge clk);
        check_idle("no_timeout_end");
`endif
        silent[2] = 1'b0;
        clr_err("clr3");

        // Reset in the middle of an ACTIVE transfer with an error captured
        v = '{32'h0000_7000, 1'b0, 2'd1, 32'h0, 3'b000, 3'b000, 2, 1'b1, 2'b01, 32'h7000};
        run_vec(v, 1'b0, "miss7000");
        lat[0] = 6;
        @(posedge clk); #1 master_drive(32'h0000_0008, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_reset", "active_cyc", {125'd0, bus.wbs_cyc_o}, 128'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset", "cyc_drop", {125'd0, bus.wbs_cyc_o, bus.wbs_stb_o}, 128'd0);
        check("mid_reset", "no_rsp", {125'd0, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 128'd0);
        check("mid_reset", "err_regs", {93'd0, err_valid, err_code, err_adr}, 128'd0);
        master_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        lat[0] = 1;
        v = '{32'h0000_1004, 1'b0, 2'd0, 32'hCAFE_0001, 3'b010, 3'b010, 4, 1'b0, 2'b00, 32'h0};
        run_vec(v, 1'b0, "post_reset1");
        v = '{32'h0000_0008, 1'b0, 2'd0, 32'hCAFE_0000, 3'b001, 3'b001, 3, 1'b0, 2'b00, 32'h0};
        run_vec(v, 1'b0, "post_reset0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_slave_decoder.md
WB_SLAVE_DECODER -- requirements
Module: wb_slave_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 11: number of slave ports, 1..32.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width; select width is DW/8.
REQ-004 SHALL have parameter MATCH_ADDR, default all zero: NUM_SLAVES*AW flat vector; slice i is slave i base address.
REQ-005 SHALL have parameter MATCH_MASK, default all zero: NUM_SLAVES*AW flat vector; slice i is slave i mask.
REQ-006 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for a slave response, 2..65535.
REQ-007 SHALL have these master-side ports:
- wb_clk_i  in  1: clock.
- wb_rst_n_i  in  1: reset; asynchronous, active-low.
- wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i[2:0], wbm_bte_i[1:0]  in: master request.
- wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o  out: master response.
REQ-008 SHALL have these slave-side ports:
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out: flat NUM_SLAVES-wide request vectors.
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in: flat NUM_SLAVES-wide response vectors.
- In every flat vector, slave 0 occupies the LSB slice.
REQ-009 SHALL have these error-capture ports:
- err_valid_o  out  1: sticky error flag.
- err_code_o  out  2: 01 decode miss, 10 timeout.
- err_adr_o  out  AW: captured failing address.
- err_clr_i  in  1: clears the error capture.

Function
REQ-010 SHALL broadcast wbm adr/dat/sel/we/cti/bte unmodified to every slave slice.
REQ-011 SHALL decode slave i as a hit when (wbm_adr_i & MASK[i]) == (ADDR[i] & MASK[i]); on multiple hits, the lowest index wins.
REQ-012 SHALL implement FSM states IDLE, ACTIVE, DECERR, TMOERR.
REQ-013 SHALL, in IDLE with wbm_cyc_i&wbm_stb_i set, register the one-hot select and move next cycle to ACTIVE on a hit or DECERR on a miss.
REQ-014 SHALL, in ACTIVE, drive wbs_cyc_o[sel]=wbm_cyc_i and wbs_stb_o[sel]=wbm_stb_i, and hold all other slice cyc/stb at 0.
REQ-015 SHALL, in ACTIVE, pass selected ack/err/rty/dat combinationally to the master; responses from unselected slaves SHALL be ignored.
REQ-016 SHALL return from ACTIVE to IDLE on the cycle after any selected ack/err/rty; each beat of a burst is therefore re-decoded, adding one cycle of latency per beat.
REQ-017 SHALL, if wbm_cyc_i deasserts in ACTIVE, deassert slave cyc in the same cycle and enter IDLE next cycle.
REQ-018 SHALL, in DECERR, assert wbm_err_o for exactly one cycle, drive no slave, then enter IDLE.
REQ-019 SHALL, in every state, hold wbm_dat_o at 0 whenever no slave is being forwarded.
REQ-020 SHALL, on entry to DECERR or TMOERR while err_valid_o=0, capture code and address and set err_valid_o; while err_valid_o=1, later errors SHALL NOT overwrite the capture.
REQ-021 SHALL clear err_valid_o, err_code_o and err_adr_o on err_clr_i; when err_clr_i coincides with a new error, the new error SHALL be captured.

Reset
REQ-022 SHALL, with wb_rst_n_i low, asynchronously force the FSM to IDLE, select to 0, timeout counter to 0, and err_valid_o/err_code_o/err_adr_o to 0.
REQ-023 SHALL, during reset, hold all wbs_cyc_o/wbs_stb_o and wbm_ack_o/err_o/rty_o at 0; a transfer in flight is abandoned without a response.
REQ-024 SHALL release reset synchronously to wb_clk_i and be ready in IDLE on the first clock edge after release.

Configuration
REQ-025 SHALL include a response watchdog only when WB_DECODE_TIMEOUT_EN is defined. The watchdog behaves as follows:
- The counter clears on entry to ACTIVE and increments on each ACTIVE cycle without a response.
- On reaching TIMEOUT-1 it enters TMOERR.
- In TMOERR it drops slave cyc/stb, asserts wbm_err_o for one cycle, then enters IDLE.
REQ-026 SHALL, without WB_DECODE_TIMEOUT_EN, omit the counter and TMOERR logic; ACTIVE then waits indefinitely and err_code_o=10 never occurs.

Verification
REQ-027 Use NUM_SLAVES=3, ADDR={0x2000,0x1000,0x0000}, MASK={0xFFFFF000,0xFFFFFFC0,0xFFFFF000}.
- Read 0x1004, slave1 acks after 2 cycles with 0xCAFE0001 -> only wbs_cyc_o[1] asserted; wbm_dat_o=0xCAFE0001 with ack; FSM back in IDLE.
- Write 0x3000 (miss) -> no slave cyc; wbm_err_o pulses one cycle 2 cycles after stb; err_valid_o=1, err_code_o=01, err_adr_o=0x3000.
- Second miss to 0x4000 while err_valid_o=1 -> err_adr_o remains 0x3000; after err_clr_i pulse, err_valid_o=0.
- With WB_DECODE_TIMEOUT_EN and TIMEOUT=8, access 0x2010 with slave2 silent -> wbs_cyc_o[2] drops and wbm_err_o pulses 9 cycles after ACTIVE entry; err_code_o=10.
- Reset asserted mid-ACTIVE at 0x0008 -> wbs_cyc_o=0 immediately, no ack; a new read after release completes normally.
